// File: rtl/arm_regbank_pkg.sv
// Shared constants for the ARM register-bank sequencer: mode encodings,
// physical bank indices and the sequencer state type.
package arm_regbank_pkg;

    localparam logic [4:0] MODE_USR = 5'b10000;
    localparam logic [4:0] MODE_FIQ = 5'b10001;
    localparam logic [4:0] MODE_IRQ = 5'b10010;
    localparam logic [4:0] MODE_SVC = 5'b10011;
    localparam logic [4:0] MODE_ABT = 5'b10111;
    localparam logic [4:0] MODE_UND = 5'b11011;
    localparam logic [4:0] MODE_SYS = 5'b11111;

    localparam int unsigned PHYS_PC       = 15;
    localparam int unsigned PHYS_USR_SP   = 13;
    localparam int unsigned PHYS_FIQ_BASE = 16;
    localparam int unsigned PHYS_FIQ_SP   = 21;
    localparam int unsigned PHYS_SVC_SP   = 23;
    localparam int unsigned PHYS_ABT_SP   = 25;
    localparam int unsigned PHYS_IRQ_SP   = 27;
    localparam int unsigned PHYS_UND_SP   = 29;
    localparam int unsigned PHYS_CPSR     = 31;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_RESP
    } seq_state_e;

    function automatic logic mode_is_valid(input logic [4:0] mode);
        return mode inside {MODE_USR, MODE_FIQ, MODE_IRQ, MODE_SVC,
                            MODE_ABT, MODE_UND, MODE_SYS};
    endfunction

endpackage

// File: rtl/regbank_mode_map.sv
// Combinational map from (processor mode, logical register) to physical bank
// index. Unlisted modes map as USR and raise mode_err.
module regbank_mode_map
    import arm_regbank_pkg::*;
#(
    parameter int unsigned AW = 5
) (
    input  logic [4:0]    mode,
    input  logic [3:0]    lreg,
    output logic [AW-1:0] phys,
    output logic          mode_err
);

    int unsigned sp_base;
    int unsigned idx;

    always_comb begin
        mode_err = !mode_is_valid(mode);
        sp_base  = PHYS_USR_SP;
        unique case (mode)
            MODE_FIQ: sp_base = PHYS_FIQ_SP;
            MODE_SVC: sp_base = PHYS_SVC_SP;
            MODE_ABT: sp_base = PHYS_ABT_SP;
            MODE_IRQ: sp_base = PHYS_IRQ_SP;
            MODE_UND: sp_base = PHYS_UND_SP;
            default:  sp_base = PHYS_USR_SP;
        endcase

        idx = 32'(lreg);
        if ((mode == MODE_FIQ) && (lreg inside {[4'd8:4'd12]}))
            idx = PHYS_FIQ_BASE + 32'(lreg) - 32'd8;
        else if ((lreg == 4'd13) || (lreg == 4'd14))
            idx = sp_base + 32'(lreg) - 32'd13;
        phys = AW'(idx);
    end

endmodule

// File: rtl/regbank_sequencer.sv
// Register-bank initiator: latches one request, runs a read phase then an
// optional write phase on the bank, and returns captured operands.
module regbank_sequencer
    import arm_regbank_pkg::*;
#(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          req_valid,
    output logic          req_ready,
    input  logic [4:0]    req_mode,
    input  logic [3:0]    req_ra,
    input  logic [3:0]    req_rb,
    input  logic [3:0]    req_rc,
    input  logic          req_wb_en,
    input  logic [3:0]    req_wb_rd,
    input  logic [DW-1:0] req_wb_data,
    input  logic          req_pc_inc,
    input  logic          req_cpsr_w,
    input  logic [DW-1:0] req_cpsr_data,
    input  logic [DW-1:0] req_cpsr_mask,

    output logic          rb_clk1,
    output logic          rb_clk2,
    output logic          rb_is_active,
    output logic [AW-1:0] rb_address1,
    output logic [AW-1:0] rb_address2,
    output logic [AW-1:0] rb_address3,
    output logic          rb_w,
    output logic          rb_pc_w,
    output logic          rb_pc_increment,
    output logic          rb_cpsr_w,
    output logic [DW-1:0] rb_write,
    output logic [DW-1:0] rb_pc_write,
    output logic [DW-1:0] rb_cpsr_write,
    output logic [DW-1:0] rb_cpsr_mask,
    input  logic [DW-1:0] rb_read1,
    input  logic [DW-1:0] rb_read2,
    input  logic [DW-1:0] rb_read3,
    input  logic [DW-1:0] rb_pc_read,

    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_a,
    output logic [DW-1:0] rsp_b,
    output logic [DW-1:0] rsp_c,
    output logic [DW-1:0] rsp_pc,
    output logic          rsp_mode_err
);

    seq_state_e    state_q, state_d;
    logic [4:0]    mode_q, mode_d;
    logic [3:0]    ra_q, ra_d, rb_q, rb_d, rc_q, rc_d, wb_rd_q, wb_rd_d;
    logic          wb_en_q, wb_en_d, pc_inc_q, pc_inc_d, cpsr_w_q, cpsr_w_d;
    logic [DW-1:0] wb_data_q, wb_data_d;
    logic [DW-1:0] cpsr_data_q, cpsr_data_d, cpsr_mask_q, cpsr_mask_d;
    logic [DW-1:0] rsp_a_q, rsp_a_d, rsp_b_q, rsp_b_d;
    logic [DW-1:0] rsp_c_q, rsp_c_d, rsp_pc_q, rsp_pc_d;
    logic          mode_err_q, mode_err_d;

    logic [AW-1:0] phys_a, phys_b, phys_c, phys_wb;
    logic          err_a, err_b, err_c, err_wb;

    regbank_mode_map #(.AW(AW)) u_map_a (
        .mode(mode_q), .lreg(ra_q), .phys(phys_a), .mode_err(err_a));
    regbank_mode_map #(.AW(AW)) u_map_b (
        .mode(mode_q), .lreg(rb_q), .phys(phys_b), .mode_err(err_b));
    regbank_mode_map #(.AW(AW)) u_map_c (
        .mode(mode_q), .lreg(rc_q), .phys(phys_c), .mode_err(err_c));
    regbank_mode_map #(.AW(AW)) u_map_wb (
        .mode(mode_q), .lreg(wb_rd_q), .phys(phys_wb), .mode_err(err_wb));

    assign rsp_a  = rsp_a_q;
    assign rsp_b  = rsp_b_q;
    assign rsp_c  = rsp_c_q;
    assign rsp_pc = rsp_pc_q;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        ra_d        = ra_q;
        rb_d        = rb_q;
        rc_d        = rc_q;
        wb_en_d     = wb_en_q;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        pc_inc_d    = pc_inc_q;
        cpsr_w_d    = cpsr_w_q;
        cpsr_data_d = cpsr_data_q;
        cpsr_mask_d = cpsr_mask_q;
        rsp_a_d     = rsp_a_q;
        rsp_b_d     = rsp_b_q;
        rsp_c_d     = rsp_c_q;
        rsp_pc_d    = rsp_pc_q;
        mode_err_d  = mode_err_q;

        req_ready       = 1'b0;
        rb_clk1         = 1'b0;
        rb_clk2         = 1'b0;
        rb_is_active    = 1'b0;
        rb_address1     = '0;
        rb_address2     = '0;
        rb_address3     = '0;
        rb_w            = 1'b0;
        rb_pc_w         = 1'b0;
        rb_pc_increment = 1'b0;
        rb_cpsr_w       = 1'b0;
        rb_write        = '0;
        rb_pc_write     = '0;
        rb_cpsr_write   = '0;
        rb_cpsr_mask    = '0;
        rsp_valid       = 1'b0;
        rsp_mode_err    = 1'b0;

        // Reset gates every output combinationally so an aborted phase never strobes the bank.
        if (!rst) begin
            unique case (state_q)
                ST_IDLE: begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        mode_d      = req_mode;
                        ra_d        = req_ra;
                        rb_d        = req_rb;
                        rc_d        = req_rc;
                        wb_en_d     = req_wb_en;
                        wb_rd_d     = req_wb_rd;
                        wb_data_d   = req_wb_data;
                        pc_inc_d    = req_pc_inc;
                        cpsr_w_d    = req_cpsr_w;
                        cpsr_data_d = req_cpsr_data;
                        cpsr_mask_d = req_cpsr_mask;
                        state_d     = ST_READ;
                    end
                end
                ST_READ: begin
                    rb_clk1         = 1'b1;
                    rb_is_active    = 1'b1;
                    rb_address1     = phys_a;
                    rb_address2     = phys_b;
                    rb_address3     = phys_c;
                    rb_pc_increment = pc_inc_q;
                    rsp_a_d         = rb_read1;
                    rsp_b_d         = rb_read2;
                    rsp_c_d         = rb_read3;
                    rsp_pc_d        = rb_pc_read;
                    mode_err_d      = err_a | err_b | err_c | err_wb;
                    state_d         = (wb_en_q || cpsr_w_q) ? ST_WRITE : ST_RESP;
                end
                ST_WRITE: begin
                    rb_clk2 = 1'b1;
                    if (wb_en_q) begin
                        if (wb_rd_q == 4'd15) begin
                            rb_pc_w     = 1'b1;
                            rb_pc_write = wb_data_q;
                        end else begin
                            rb_w        = 1'b1;
                            rb_address1 = phys_wb;
                            rb_write    = wb_data_q;
                        end
                    end
                    if (cpsr_w_q) begin
                        rb_cpsr_w     = 1'b1;
                        rb_cpsr_write = cpsr_data_q;
                        rb_cpsr_mask  = cpsr_mask_q;
                    end
                    state_d = ST_RESP;
                end
                ST_RESP: begin
                    rsp_valid    = 1'b1;
                    rsp_mode_err = mode_err_q;
                    if (rsp_ready)
                        state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mode_q      <= '0;
            ra_q        <= '0;
            rb_q        <= '0;
            rc_q        <= '0;
            wb_en_q     <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            pc_inc_q    <= 1'b0;
            cpsr_w_q    <= 1'b0;
            cpsr_data_q <= '0;
            cpsr_mask_q <= '0;
            rsp_a_q     <= '0;
            rsp_b_q     <= '0;
            rsp_c_q     <= '0;
            rsp_pc_q    <= '0;
            mode_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            ra_q        <= ra_d;
            rb_q        <= rb_d;
            rc_q        <= rc_d;
            wb_en_q     <= wb_en_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            pc_inc_q    <= pc_inc_d;
            cpsr_w_q    <= cpsr_w_d;
            cpsr_data_q <= cpsr_data_d;
            cpsr_mask_q <= cpsr_mask_d;
            rsp_a_q     <= rsp_a_d;
            rsp_b_q     <= rsp_b_d;
            rsp_c_q     <= rsp_c_d;
            rsp_pc_q    <= rsp_pc_d;
            mode_err_q  <= mode_err_d;
        end
    end

endmodule
